// File: rtl/series_accumulator.sv
// Streaming series accumulator: sums a run of len samples in one of three modes
// and hands the result out on a valid/ready port. Optional SERIES_ACC_SAT_EN saturates instead of wrapping.
module series_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_LEN    = 1024,
  parameter int CNT_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      len,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  sum_output,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam int               PAD_W     = ACC_WIDTH - DATA_WIDTH;

  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      len_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [1:0]            mode_reg;
  logic [ACC_WIDTH-1:0]  acc_reg;
  logic [ACC_WIDTH-1:0]  sum_reg;
  logic                  ovf_reg;

  logic [CNT_W-1:0]      len_clamped;
  logic                  signed_mode;
  logic [DATA_WIDTH-1:0] abs_data;
  logic [ACC_WIDTH-1:0]  ext_data;
  logic [ACC_WIDTH:0]    sum_wide;
  logic [ACC_WIDTH-1:0]  sum_raw;
  logic                  beat_ovf;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  beat;
  logic                  last_beat;

  assign len_clamped = (len > MAX_LEN_C) ? MAX_LEN_C : len;
  // Modes 1 and 3 are the signed modes; bit 0 alone identifies them.
  assign signed_mode = mode_reg[0];
  assign abs_data    = in_data[DATA_WIDTH-1] ? (~in_data + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : in_data;

  always_comb begin
    ext_data = {{PAD_W{in_data[DATA_WIDTH-1]}}, in_data};
    case (mode_reg)
      2'd0:    ext_data = {{PAD_W{1'b0}}, in_data};
      2'd2:    ext_data = {{PAD_W{1'b0}}, abs_data};
      default: ext_data = {{PAD_W{in_data[DATA_WIDTH-1]}}, in_data};
    endcase
  end

  assign sum_wide = {1'b0, acc_reg} + {1'b0, ext_data};
  assign sum_raw  = sum_wide[ACC_WIDTH-1:0];

  // Signed overflow: both operands share a sign that the result does not.
  always_comb begin
    if (signed_mode) begin
      beat_ovf = (acc_reg[ACC_WIDTH-1] == ext_data[ACC_WIDTH-1]) &&
                 (sum_raw[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);
    end else begin
      beat_ovf = sum_wide[ACC_WIDTH];
    end
  end

`ifdef SERIES_ACC_SAT_EN
  always_comb begin
    acc_next = sum_raw;
    if (beat_ovf) begin
      if (!signed_mode) begin
        acc_next = {ACC_WIDTH{1'b1}};
      end else if (acc_reg[ACC_WIDTH-1]) begin
        acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign acc_next = sum_raw;
`endif

  assign beat      = (state_reg == ST_RUN) && in_valid;
  assign last_beat = beat && (count_reg == (len_reg - ONE_C));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      mode_reg  <= 2'd0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg   <= len_clamped;
            mode_reg  <= mode;
            count_reg <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            if (len_clamped == '0) begin
              sum_reg   <= '0;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (beat) begin
            acc_reg   <= acc_next;
            count_reg <= count_reg + ONE_C;
            if (beat_ovf) ovf_reg <= 1'b1;
            if (last_beat) begin
              sum_reg   <= acc_next;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == ST_RUN);
  assign out_valid  = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);
  assign sum_output = sum_reg;
  assign overflow   = ovf_reg;

endmodule

// File: tb/tb_series_accumulator.sv
// Directed bench for series_accumulator: a 32/40-bit instance and an 8/10-bit instance
// share the stimulus bus; expected results go through a scoreboard queue.
module tb_series_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [10:0] len;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, busy_a, overflow_a;
  logic [39:0] sum_a;
  logic        in_ready_b, out_valid_b, busy_b, overflow_b;
  logic [9:0]  sum_b;

  int checks = 0;
  int errors = 0;
  logic sel = 1'b0;

  typedef struct {
    logic [39:0] sum;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  series_accumulator dut_a (
    .clk(clk), .reset(reset), .start(start_a), .len(len), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .sum_output(sum_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a), .overflow(overflow_a)
  );

  series_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .len(len), .mode(mode),
    .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(in_ready_b),
    .sum_output(sum_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .overflow(overflow_b)
  );

  function automatic logic cur_in_ready();
    return sel ? in_ready_b : in_ready_a;
  endfunction
  function automatic logic cur_out_valid();
    return sel ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic cur_busy();
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic cur_ovf();
    return sel ? overflow_b : overflow_a;
  endfunction
  function automatic logic [39:0] cur_sum();
    return sel ? {30'd0, sum_b} : sum_a;
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic start_run(input logic s, input int l, input logic [1:0] m);
    sel  = s;
    len  = 11'(l);
    mode = m;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("in_ready_after_start", {39'd0, cur_in_ready()}, {39'd0, (l != 0)});
    check("out_valid_after_start", {39'd0, cur_out_valid()}, {39'd0, (l == 0)});
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    while (cur_in_ready() !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 40'd0, 40'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks latency right after the final beat.
  task automatic after_last_beat(input string tag);
    check({tag, "_out_valid_latency"}, {39'd0, cur_out_valid()}, 40'd1);
    check({tag, "_in_ready_done"}, {39'd0, cur_in_ready()}, 40'd0);
  endtask

  task automatic collect(input string tag, input int hold, input logic pulse_start);
    int n;
    exp_t e;
    logic [39:0] held;
    n = 0;
    while (cur_out_valid() !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_out_valid_timeout"}, 40'd0, 40'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 40'd0, 40'd1);
      e.sum = '0;
      e.ovf = 1'b0;
    end else begin
      e = sb_q.pop_front();
    end
    check({tag, "_sum"}, cur_sum(), e.sum);
    check({tag, "_overflow"}, {39'd0, cur_ovf()}, {39'd0, e.ovf});
    held = cur_sum();
    for (int i = 0; i < hold; i++) begin
      if (pulse_start) begin
        len = 11'd5;
        if (sel) start_b = i[0]; else start_a = i[0];
      end
      @(negedge clk);
      check({tag, "_held_valid"}, {39'd0, cur_out_valid()}, 40'd1);
      check({tag, "_held_sum"}, cur_sum(), e.sum);
    end
    if (pulse_start) begin
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    check({tag, "_out_valid_cleared"}, {39'd0, cur_out_valid()}, 40'd0);
    check({tag, "_idle_after_ack"}, {39'd0, cur_busy()}, 40'd0);
    $display("result %s: sum=%0h overflow=%0b", tag, held, e.ovf);
  endtask

  task automatic push(input logic [39:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] exp4;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; len = '0; mode = 2'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_out_valid", {38'd0, out_valid_a, out_valid_b}, 40'd0);
    check("reset_busy", {38'd0, busy_a, busy_b}, 40'd0);
    check("reset_in_ready", {38'd0, in_ready_a, in_ready_b}, 40'd0);
    check("reset_sum_a", sum_a, 40'd0);

    // Zero-length run completes on the next cycle with no in_ready pulse.
    push(40'd0, 1'b0);
    start_run(1'b0, 0, 2'd0);
    collect("len0", 1, 1'b0);

    // Mode 0, 1..10 back to back.
    push(40'd55, 1'b0);
    start_run(1'b0, 10, 2'd0);
    for (int i = 1; i <= 10; i++) send(32'(i), 0);
    after_last_beat("t1");
    collect("t1", 0, 1'b0);

    // Mode 1 with idle gaps between samples.
    push(40'hFF_FFFF_FFFA, 1'b0);
    start_run(1'b0, 4, 2'd1);
    send(32'd5, 2);
    send(-32'sd3, 2);
    send(-32'sd10, 2);
    send(32'd2, 2);
    after_last_beat("t2");
    collect("t2", 2, 1'b0);

    // Narrow instance, mode 2: |-128| + 127 + |-1|.
    push(40'd256, 1'b0);
    start_run(1'b1, 3, 2'd2);
    send(32'h80, 0);
    send(32'h7F, 1);
    send(32'hFF, 0);
    after_last_beat("t3");
    collect("t3", 0, 1'b0);

    // Narrow instance, mode 0: 5 x 255 exceeds 10 bits.
`ifdef SERIES_ACC_SAT_EN
    exp4 = 40'd1023;
`else
    exp4 = 40'd251;
`endif
    push(exp4, 1'b1);
    start_run(1'b1, 5, 2'd0);
    for (int i = 0; i < 5; i++) send(32'hFF, 0);
    after_last_beat("t4");
    collect("t4", 0, 1'b0);

    // Reset mid-run discards the run.
    start_run(1'b0, 8, 2'd0);
    send(32'd100, 0);
    send(32'd200, 0);
    send(32'd300, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_reset_sum", sum_a, 40'd0);
    check("t6_reset_state", {37'd0, busy_a, out_valid_a, in_ready_a}, 40'd0);
    check("t6_reset_overflow", {39'd0, overflow_a}, 40'd0);

    push(40'd15, 1'b0);
    start_run(1'b0, 2, 2'd0);
    send(32'd7, 0);
    send(32'd8, 0);
    after_last_beat("t6");
    collect("t6", 5, 1'b1);
    @(negedge clk);
    check("t6_start_ignored", {39'd0, busy_a}, 40'd0);
    check("scoreboard_drained", 40'(sb_q.size()), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
